// File: rtl/payload_pkg.sv
// Shared definitions for the payload extractor: FSM state encodings and the
// default frame start marker.
package payload_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/payload_gap_timer.sv
// Inter-byte gap timer. Counts idle cycles inside a frame. 'expired' flags the
// idle cycle that brings the gap to TIMEOUT, so the owner can abort on that
// same edge. Stalled cycles freeze the count; 'clear' restarts it.
module payload_gap_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  assign expired = !clear && !stall && (cnt == LAST);

  // Idle-cycle counter; saturates at LAST until the frame is aborted or a byte arrives.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (!stall && (cnt != LAST)) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/payload_extractor.sv
// Byte-stream frame parser: SYNC, LEN, payload[LEN], optional CHK.
// Payload bytes go straight to the FIFO write port (zero latency); fifo_full
// backpressures the input. Optional checksum byte enabled by the macro
// PAYLOAD_CHECKSUM_EN (XOR of payload bytes).
//
// state      | meaning
// ST_HUNT    | discard bytes until SYNC_BYTE
// ST_LEN     | next byte is the payload length
// ST_PAYLOAD | forward remaining payload bytes to the FIFO
// ST_CHK     | next byte is the XOR checksum (checksum build only)
module payload_extractor
  import payload_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 255,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_data,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_count
);

  state_t     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic       done_d, err_d;
  logic       accept;
  logic       gap_clear, gap_stall, gap_expired;
`ifdef PAYLOAD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  // Handshake and write path are combinational; reset gates both off.
  assign in_ready     = !rst && !((state_q == ST_PAYLOAD) && fifo_full);
  assign accept       = in_valid && in_ready;
  assign fifo_wr_en   = accept && (state_q == ST_PAYLOAD);
  assign fifo_wr_data = in_data;

  // FIFO-full stalls are the sender waiting on us, so they do not age the gap.
  assign gap_clear = accept || (state_q == ST_HUNT);
  assign gap_stall = (state_q == ST_PAYLOAD) && in_valid && fifo_full;

  payload_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .stall   (gap_stall),
    .expired (gap_expired)
  );

  // Next-state, remaining count and frame verdict.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef PAYLOAD_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          remain_d = in_data;
`ifdef PAYLOAD_CHECKSUM_EN
          chk_d    = 8'h00;
`endif
          if (in_data == 8'd0) begin
`ifdef PAYLOAD_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_HUNT;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          remain_d = remain_q - 8'd1;
`ifdef PAYLOAD_CHECKSUM_EN
          chk_d    = chk_q ^ in_data;
`endif
          if (remain_q == 8'd1) begin
`ifdef PAYLOAD_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_HUNT;
            done_d  = 1'b1;
`endif
          end
        end
      end
      ST_CHK: begin
`ifdef PAYLOAD_CHECKSUM_EN
        if (accept) begin
          state_d = ST_HUNT;
          if (in_data == chk_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end
`else
        state_d = ST_HUNT;
`endif
      end
      default: state_d = ST_HUNT;
    endcase
    if (gap_expired && (state_q != ST_HUNT)) begin
      state_d = ST_HUNT;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HUNT;
    else     state_q <= state_d;
  end

  // Datapath registers, registered verdict pulses and good-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q    <= 8'd0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
`ifdef PAYLOAD_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      remain_q   <= remain_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      if (done_d) frame_count <= frame_count + CNT_W'(1);
`ifdef PAYLOAD_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_payload_extractor.sv
// Self-checking bench for payload_extractor. A frame-level model (byte counts,
// running XOR, idle-gap count) predicts every output each cycle; directed
// tests also pin the model with literal write lists and pulse counts.
// Honours PAYLOAD_CHECKSUM_EN the same way as the design.
module tb_payload_extractor;

  localparam int         TO   = 8;
  localparam int         CW   = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk, rst, in_valid, in_ready, fifo_full, fifo_wr_en;
  logic          frame_done, frame_err;
  logic [7:0]    in_data, fifo_wr_data;
  logic [CW-1:0] frame_count;

  payload_extractor #(.SYNC_BYTE(SYNC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit            m_in = 0, m_have_len = 0;
  int            m_len = 0, m_got = 0, m_idle = 0;
  logic [7:0]    m_x = 8'h00;
  logic          exp_done = 1'b0, exp_err = 1'b0;
  logic [CW-1:0] exp_count = '0;

  always @(negedge clk) begin : cmp_blk
    logic payload, er, acc, ew, nd, ne, last;
    if (checking) begin
      payload = m_in && m_have_len && (m_got < m_len);
      er  = !rst && !(payload && fifo_full);
      acc = in_valid && er;
      ew  = acc && payload;
      check("in_ready", in_ready, er);
      check("fifo_wr_en", fifo_wr_en, ew);
      if (ew) check("fifo_wr_data", fifo_wr_data, in_data);
      check("frame_done", frame_done, exp_done);
      check("frame_err", frame_err, exp_err);
      check("frame_count", frame_count, exp_count);
      nd = 1'b0;
      ne = 1'b0;
      if (rst) begin
        m_in = 0;
        exp_count = '0;
      end else if (!m_in) begin
        if (acc && in_data == SYNC) begin
          m_in = 1; m_have_len = 0; m_idle = 0;
        end
      end else if (acc) begin
        m_idle = 0;
        last = 1'b0;
        if (!m_have_len) begin
          m_have_len = 1; m_len = int'(in_data); m_got = 0; m_x = 8'h00;
          last = (m_len == 0);
        end else if (m_got < m_len) begin
          m_got++;
          m_x = m_x ^ in_data;
          last = (m_got == m_len);
        end else begin
          if (in_data == m_x) nd = 1'b1;
          else                ne = 1'b1;
          m_in = 0;
        end
`ifndef PAYLOAD_CHECKSUM_EN
        if (last) begin
          nd = 1'b1;
          m_in = 0;
        end
`endif
      end else if (!(in_valid && payload && fifo_full)) begin
        m_idle++;
        if (m_idle >= TO) begin
          ne = 1'b1;
          m_in = 0;
        end
      end
      exp_done = nd;
      exp_err  = ne;
      if (nd) exp_count = exp_count + CW'(1);
    end
  end

  // ---------------- observation log ----------------
  logic [7:0] wr_log[$];
  int n_done = 0, n_errp = 0;

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_wr_data);
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_errp++;
  end

  task automatic clear_log();
    wr_log.delete();
    n_done = 0;
    n_errp = 0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] tx[$];

  task automatic check_log(input string name);
    check({name, "_nwr"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check(name, wr_log[i], exp_q[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_all();
    for (int i = 0; i < tx.size(); i++) send(tx[i]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_count", frame_count, 0);
    check("rst_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: basic frame
    clear_log();
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'h00);
`endif
    send_all(); idle(2);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_log("t1_wr");
    check("t1_done", n_done, 1);
    check("t1_err", n_errp, 0);
    check("t1_count", frame_count, 1);

    // T2: junk before sync, sync byte as payload
    clear_log();
    tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'hA5);
`endif
    send_all(); idle(2);
    exp_q = '{8'hA5};
    check_log("t2_wr");
    check("t2_done", n_done, 1);
    check("t2_count", frame_count, 2);

    // T2b: zero-length frame
    clear_log();
    tx = '{8'hA5, 8'h00};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'h00);
`endif
    send_all(); idle(2);
    exp_q = {};
    check_log("t2b_wr");
    check("t2b_done", n_done, 1);
    check("t2b_count", frame_count, 3);

    // T3: FIFO full for 10 cycles mid-payload (longer than TO)
    clear_log();
    tx = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_all();
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    repeat (10) begin
      @(negedge clk);
      check("t3_stall_ready", in_ready, 0);
      check("t3_stall_wr", fifo_wr_en, 0);
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    tx = '{8'h03, 8'h04};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'h04);
`endif
    send_all(); idle(2);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_log("t3_wr");
    check("t3_done", n_done, 1);
    check("t3_err", n_errp, 0);
    check("t3_count", frame_count, 4);

    // T4: gap timeout, then a clean frame
    clear_log();
    tx = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_all(); idle(TO);
    @(negedge clk);
    check("t4_err_now", frame_err, 1);
    idle(1);
    tx = '{8'hA5, 8'h01, 8'h77};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'h77);
`endif
    send_all(); idle(2);
    exp_q = '{8'h01, 8'h02, 8'h77};
    check_log("t4_wr");
    check("t4_done", n_done, 1);
    check("t4_err", n_errp, 1);
    check("t4_count", frame_count, 5);

`ifdef PAYLOAD_CHECKSUM_EN
    // T5: bad then good checksum
    clear_log();
    tx = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
    send_all(); idle(2);
    check("t5_bad_err", n_errp, 1);
    check("t5_bad_done", n_done, 0);
    check("t5_bad_count", frame_count, 5);
    tx = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFF};
    send_all(); idle(2);
    exp_q = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};
    check_log("t5_wr");
    check("t5_done", n_done, 1);
    check("t5_err", n_errp, 1);
    check("t5_count", frame_count, 6);
`endif

    // T6: reset mid-payload
    clear_log();
    tx = '{8'hA5, 8'h05, 8'h01, 8'h02};
    send_all();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    repeat (2) begin
      @(negedge clk);
      check("t6_rst_ready", in_ready, 0);
      check("t6_rst_wr", fifo_wr_en, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t6_count0", frame_count, 0);
    check("t6_done0", frame_done, 0);
    check("t6_err0", frame_err, 0);
    idle(TO + 2);
    tx = '{8'h03, 8'hA5, 8'h01, 8'h5C};
`ifdef PAYLOAD_CHECKSUM_EN
    tx.push_back(8'h5C);
`endif
    send_all(); idle(2);
    exp_q = '{8'h01, 8'h02, 8'h5C};
    check_log("t6_wr");
    check("t6_done", n_done, 1);
    check("t6_err", n_errp, 0);
    check("t6_count", frame_count, 1);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
